// File: rtl/uart_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_div_pkg
//  Description : Shared encodings for the UART-to-divider framer: receiver
//                and assembler state codes plus the err_cause values.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_div_pkg;

    // Byte receiver states
    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    // Frame assembler states: waiting for dividend byte 0/1/2, or divisor
    localparam logic [1:0] AS_W0 = 2'd0;
    localparam logic [1:0] AS_W1 = 2'd1;
    localparam logic [1:0] AS_W2 = 2'd2;
    localparam logic [1:0] AS_WD = 2'd3;

    // err_cause codes
    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_STOP = 2'b01;
    localparam logic [1:0] ERR_ZERO = 2'b10;
    localparam logic [1:0] ERR_TMO  = 2'b11;

endpackage
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_byte
//  Description : 8N1 UART byte receiver with 2-flop input synchronizer.
//                Samples each bit at its centre and reports either a good
//                byte or a stop-bit (framing) error as one-cycle pulses.
//  Ports       : clk        - rising-edge clock
//                reset      - asynchronous active-high reset
//                rx         - serial input, idle high, asynchronous to clk
//                byte_data  - received byte, valid with byte_valid
//                byte_valid - one-cycle pulse, byte received with stop = 1
//                byte_ferr  - one-cycle pulse, stop bit sampled as 0
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       byte_ferr
);
    import uart_div_pkg::*;

    localparam int c_cnt_w = $clog2(CLKS_PER_BIT);
    // The falling edge is acted on one cycle after it shows at the
    // synchronizer output, and the down-counter needs one more cycle to hit
    // zero, hence the -2: the start-bit sample lands at CLKS_PER_BIT/2
    // cycles after the edge reaches the synchronized line.
    localparam logic [c_cnt_w-1:0] c_half_load = c_cnt_w'(CLKS_PER_BIT / 2 - 2);
    localparam logic [c_cnt_w-1:0] c_bit_load  = c_cnt_w'(CLKS_PER_BIT - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_prev;
    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [2:0]         r_bit;
    logic [7:0]         r_shift;
    logic [7:0]         r_byte_data;
    logic               r_byte_valid;
    logic               r_byte_ferr;

    logic w_fall;
    logic w_tick;
    logic w_load_half;
    logic w_shift_en;
    logic w_stop_ok;
    logic w_stop_bad;

    assign w_fall = r_prev & ~r_sync2;
    assign w_tick = (r_cnt == '0);

    // Synchronizer and edge-detect history; all idle high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RX_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            RX_IDLE:  if (w_fall) w_next_state = RX_START;
            // A line back high at mid start bit is a glitch, not a byte
            RX_START: if (w_tick) w_next_state = r_sync2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_tick && (r_bit == 3'd7)) w_next_state = RX_STOP;
            RX_STOP:  if (w_tick) w_next_state = RX_IDLE;
            default:  w_next_state = RX_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        w_load_half = (r_state == RX_IDLE) && w_fall;
        w_shift_en  = (r_state == RX_DATA) && w_tick;
        w_stop_ok   = (r_state == RX_STOP) && w_tick &&  r_sync2;
        w_stop_bad  = (r_state == RX_STOP) && w_tick && !r_sync2;
    end

    // Datapath: bit timer, bit index, shift register, result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt        <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_byte_data  <= '0;
            r_byte_valid <= 1'b0;
            r_byte_ferr  <= 1'b0;
        end else begin
            r_byte_valid <= w_stop_ok;
            r_byte_ferr  <= w_stop_bad;

            if (w_load_half) begin
                r_cnt <= c_half_load;
            end else if (r_state != RX_IDLE) begin
                r_cnt <= w_tick ? c_bit_load : (r_cnt - c_cnt_w'(1));
            end

            if (w_load_half) begin
                r_bit <= '0;
            end else if (w_shift_en) begin
                r_bit <= r_bit + 3'd1;
            end

            // LSB arrives first, so shift in from the top
            if (w_shift_en) begin
                r_shift <= {r_sync2, r_shift[7:1]};
            end

            if (w_stop_ok) begin
                r_byte_data <= r_shift;
            end
        end
    end

    assign byte_data  = r_byte_data;
    assign byte_valid = r_byte_valid;
    assign byte_ferr  = r_byte_ferr;

endmodule
`default_nettype wire

// File: rtl/uart_div_framer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_div_framer
//  Description : Assembles 4-byte UART command frames (24-bit big-endian
//                dividend + 8-bit divisor) and launches the divider with a
//                one-cycle flash strobe. Bad frames are dropped and reported.
//  Ports       : clk       - rising-edge clock
//                reset     - asynchronous active-high reset
//                rx        - UART serial input (8N1), idle high
//                big       - dividend, updated only on a good frame
//                smal      - divisor, updated only on a good frame
//                flash     - one-cycle pulse, good frame presented
//                frame_err - one-cycle pulse, frame dropped
//                err_cause - drop reason, held until the next drop
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_div_framer #(
    parameter int CLKS_PER_BIT = 434,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic [23:0] big,
    output logic [7:0]  smal,
    output logic        flash,
    output logic        frame_err,
    output logic [1:0]  err_cause
);
    import uart_div_pkg::*;

    localparam int c_tmo_cycles = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int c_gap_w      = $clog2(c_tmo_cycles + 1);
    localparam logic [c_gap_w-1:0] c_tmo_limit = c_gap_w'(c_tmo_cycles);

    logic [7:0] w_byte_data;
    logic       w_byte_valid;
    logic       w_byte_ferr;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .byte_data  (w_byte_data),
        .byte_valid (w_byte_valid),
        .byte_ferr  (w_byte_ferr)
    );

    // Start detection for the gap counter. Any synchronized falling edge
    // restarts the gap: the start edge of every byte is one of them, and
    // edges inside a byte only shorten a gap that is far from expiring.
    logic r_rx_s1;
    logic r_rx_s2;
    logic r_rx_prev;
    logic w_start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_s1   <= rx;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
        end
    end

    assign w_start = r_rx_prev & ~r_rx_s2;

    logic [1:0]         r_as_state;
    logic [1:0]         w_as_next;
    logic [c_gap_w-1:0] r_gap;
    logic [23:0]        r_sh_big;
    logic [23:0]        r_big;
    logic [7:0]         r_smal;
    logic               r_flash;
    logic               r_frame_err;
    logic [1:0]         r_err_cause;

    logic       w_timeout;
    logic       w_good;
    logic       w_zero;
    logic       w_tmo_err;
    logic       w_err_any;
    logic [1:0] w_cause;

    assign w_timeout = (r_as_state != AS_W0) && (r_gap == c_tmo_limit);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_as_state <= AS_W0;
        end else begin
            r_as_state <= w_as_next;
        end
    end

    // Next-state logic; byte events take priority over the timeout
    always_comb begin
        w_as_next = r_as_state;
        if (w_byte_ferr) begin
            w_as_next = AS_W0;
        end else if (w_byte_valid) begin
            case (r_as_state)
                AS_W0:   w_as_next = AS_W1;
                AS_W1:   w_as_next = AS_W2;
                AS_W2:   w_as_next = AS_WD;
                default: w_as_next = AS_W0;
            endcase
        end else if (w_timeout) begin
            w_as_next = AS_W0;
        end
    end

    // Output decode
    always_comb begin
        w_good    = w_byte_valid && (r_as_state == AS_WD) && (w_byte_data != 8'd0);
        w_zero    = w_byte_valid && (r_as_state == AS_WD) && (w_byte_data == 8'd0);
        w_tmo_err = w_timeout && !w_byte_valid && !w_byte_ferr;
        w_err_any = w_byte_ferr || w_zero || w_tmo_err;
        if (w_byte_ferr) begin
            w_cause = ERR_STOP;
        end else if (w_zero) begin
            w_cause = ERR_ZERO;
        end else begin
            w_cause = ERR_TMO;
        end
    end

    // Datapath: shadow dividend, output registers, gap counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gap       <= '0;
            r_sh_big    <= '0;
            r_big       <= '0;
            r_smal      <= '0;
            r_flash     <= 1'b0;
            r_frame_err <= 1'b0;
            r_err_cause <= ERR_NONE;
        end else begin
            r_flash     <= w_good;
            r_frame_err <= w_err_any;
            if (w_err_any) begin
                r_err_cause <= w_cause;
            end

            if (w_byte_valid) begin
                case (r_as_state)
                    AS_W0:   r_sh_big[23:16] <= w_byte_data;
                    AS_W1:   r_sh_big[15:8]  <= w_byte_data;
                    AS_W2:   r_sh_big[7:0]   <= w_byte_data;
                    default: r_sh_big        <= r_sh_big;
                endcase
            end

            if (w_good) begin
                r_big  <= r_sh_big;
                r_smal <= w_byte_data;
            end

            // Held at zero while waiting for a frame; saturates at the limit
            if ((r_as_state == AS_W0) || w_start) begin
                r_gap <= '0;
            end else if (r_gap != c_tmo_limit) begin
                r_gap <= r_gap + c_gap_w'(1);
            end
        end
    end

    assign big       = r_big;
    assign smal      = r_smal;
    assign flash     = r_flash;
    assign frame_err = r_frame_err;
    assign err_cause = r_err_cause;

endmodule
`default_nettype wire

// File: tb/tb_uart_div_framer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_div_framer
//  Description : Self-checking bench for uart_div_framer. Serial bytes are
//                driven bit by bit; a frame-level reference model predicts
//                flash / frame_err counts, outputs and strobe latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_div_framer;

    localparam int CPB = 8;
    localparam int TMO = 20;
    // Cycles from the start-bit falling edge to flash/frame_err
    localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx;
    logic [23:0] big;
    logic [7:0]  smal;
    logic        flash;
    logic        frame_err;
    logic [1:0]  err_cause;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int flash_cnt = 0;
    int err_cnt   = 0;
    int last_evt_cyc = -1;

    // Reference model state
    int          exp_flash = 0;
    int          exp_err   = 0;
    logic [23:0] exp_big   = '0;
    logic [7:0]  exp_smal  = '0;
    logic [1:0]  exp_cause = 2'b00;
    logic [7:0]  frame_q[$];
    bit          evt_here;

    uart_div_framer #(
        .CLKS_PER_BIT (CPB),
        .TIMEOUT_BITS (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .big       (big),
        .smal      (smal),
        .flash     (flash),
        .frame_err (frame_err),
        .err_cause (err_cause)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor
    always @(negedge clk) begin
        if (flash || frame_err) begin
            n_tests++;
            assert (!(flash && frame_err)) else begin
                n_fail++;
                $error("FAIL excl flash=%0b frame_err=%0b required not both", flash, frame_err);
            end
            if (flash)     flash_cnt++;
            if (frame_err) err_cnt++;
            last_evt_cyc = cyc;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".flash_cnt"}, flash_cnt, exp_flash);
        check({tag, ".err_cnt"},   err_cnt,   exp_err);
        check({tag, ".big"},       {8'h0, big},  {8'h0, exp_big});
        check({tag, ".smal"},      {24'h0, smal}, {24'h0, exp_smal});
        check({tag, ".cause"},     {30'h0, err_cause}, {30'h0, exp_cause});
    endtask

    // Frame-level behaviour: 3 dividend bytes then a divisor, stop errors
    // drop the partial frame, a zero divisor drops the whole frame.
    task automatic model_byte(input logic [7:0] b, input bit stop_ok);
        evt_here = 0;
        if (!stop_ok) begin
            frame_q.delete();
            exp_err++;
            exp_cause = 2'b01;
            evt_here  = 1;
        end else begin
            frame_q.push_back(b);
            if (frame_q.size() == 4) begin
                if (frame_q[3] == 8'd0) begin
                    exp_err++;
                    exp_cause = 2'b10;
                end else begin
                    exp_flash++;
                    exp_big  = {frame_q[0], frame_q[1], frame_q[2]};
                    exp_smal = frame_q[3];
                end
                evt_here = 1;
                frame_q.delete();
            end
        end
    endtask

    // Called at a negedge; returns at a negedge
    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        int t0;
        t0 = cyc;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_ok;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        // A low stop bit leaves the line low; give it a high bit-time
        if (!stop_ok) repeat (CPB) @(negedge clk);
        model_byte(b, stop_ok);
        check_state("byte");
        if (evt_here) check("latency", last_evt_cyc - t0, LAT);
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * CPB) @(negedge clk);
        if (n > TMO && frame_q.size() != 0) begin
            exp_err++;
            exp_cause = 2'b11;
            frame_q.delete();
        end
        check_state("idle");
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
        send_byte(b0, 1'b1);
        send_byte(b1, 1'b1);
        send_byte(b2, 1'b1);
        send_byte(b3, 1'b1);
    endtask

    initial begin
        logic [7:0] rb;
        bit         rok;

        reset = 1'b1;
        rx    = 1'b1;
        repeat (4) @(negedge clk);
        check("rst.big",   {8'h0, big}, 32'h0);
        check("rst.smal",  {24'h0, smal}, 32'h0);
        check("rst.flash", {31'h0, flash}, 32'h0);
        check("rst.ferr",  {31'h0, frame_err}, 32'h0);
        check("rst.cause", {30'h0, err_cause}, 32'h0);
        reset = 1'b0;
        idle_bits(2);

        // Good frame, then the divider's view of it
        send_frame(8'h01, 8'h02, 8'h03, 8'h07);
        check("quotient", (big / smal), 32'h24DB);

        // Zero divisor: outputs keep the previous frame
        send_frame(8'h00, 8'h10, 8'h00, 8'h00);

        // Stop-bit error in the second byte, then a good frame
        send_byte(8'hAA, 1'b1);
        send_byte(8'h55, 1'b0);
        send_frame(8'h00, 8'h00, 8'h64, 8'h05);

        // Inter-byte timeout, then a good frame
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        idle_bits(TMO + 1);
        send_frame(8'h00, 8'h00, 8'h09, 8'h03);

        // Timeout with only the first byte received
        send_byte(8'h7E, 1'b1);
        idle_bits(TMO + 1);

        // False start: two low cycles only
        rx = 1'b0;
        repeat (2) @(negedge clk);
        idle_bits(12);
        send_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom_range(1, 255)));

        // Reset in the middle of the third byte
        send_byte(8'h3C, 1'b1);
        send_byte(8'hC3, 1'b1);
        rx = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst.big",   {8'h0, big}, 32'h0);
        check("midrst.smal",  {24'h0, smal}, 32'h0);
        check("midrst.flash", {31'h0, flash}, 32'h0);
        check("midrst.ferr",  {31'h0, frame_err}, 32'h0);
        check("midrst.cause", {30'h0, err_cause}, 32'h0);
        frame_q.delete();
        exp_big   = '0;
        exp_smal  = '0;
        exp_cause = 2'b00;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        idle_bits(2);
        send_frame(8'hDE, 8'hAD, 8'hBE, 8'h11);

        // Randomized byte stream with occasional errors and long gaps
        for (int n = 0; n < 48; n++) begin
            rok = ($urandom_range(0, 9) != 0);
            if (frame_q.size() == 3 && $urandom_range(0, 4) == 0) begin
                rb = 8'h00;
            end else begin
                rb = 8'($urandom);
            end
            send_byte(rb, rok);
            if ($urandom_range(0, 11) == 0) begin
                idle_bits(TMO + 1);
            end else begin
                idle_bits(int'($urandom_range(0, 3)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
